// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter with fair tie-break and combinational owner routing.
// Define WB_ARB_TIMEOUT_EN to build the stalled-strobe timeout (TOUT state, err_o, timeout_o).
module wb_arbiter2 #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_m0_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_m0_data_i,
    input  logic                     wb_m0_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_m0_sel_i,
    input  logic                     wb_m0_stb_i,
    input  logic                     wb_m0_cyc_i,
    output logic                     wb_m0_ack_o,
    output logic                     wb_m0_err_o,
    output logic [WB_DATA_WIDTH-1:0] wb_m0_data_o,
    input  logic [WB_ADDR_WIDTH-1:0] wb_m1_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_m1_data_i,
    input  logic                     wb_m1_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_m1_sel_i,
    input  logic                     wb_m1_stb_i,
    input  logic                     wb_m1_cyc_i,
    output logic                     wb_m1_ack_o,
    output logic                     wb_m1_err_o,
    output logic [WB_DATA_WIDTH-1:0] wb_m1_data_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_s_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_s_data_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_s_sel_o,
    output logic                     wb_s_we_o,
    output logic                     wb_s_stb_o,
    output logic                     wb_s_cyc_o,
    input  logic                     wb_s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_s_data_i,
    output logic                     timeout_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [1:0] ST_TOUT = 2'd3;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    logic [1:0]               state_reg, state_next;
    logic                     last_grant_reg, last_grant_next;
    logic                     owner, owning, in_tout, tout_hit;
    logic [1:0]               m_cyc, m_stb, m_we, m_ack, m_err;
    logic [WB_ADDR_WIDTH-1:0] m_addr [2];
    logic [WB_DATA_WIDTH-1:0] m_wdata [2];
    logic [WB_DATA_WIDTH-1:0] m_rdata [2];
    logic [WB_SEL_WIDTH-1:0]  m_sel [2];

    assign m_cyc      = {wb_m1_cyc_i, wb_m0_cyc_i};
    assign m_stb      = {wb_m1_stb_i, wb_m0_stb_i};
    assign m_we       = {wb_m1_we_i, wb_m0_we_i};
    assign m_addr[0]  = wb_m0_addr_i;
    assign m_addr[1]  = wb_m1_addr_i;
    assign m_wdata[0] = wb_m0_data_i;
    assign m_wdata[1] = wb_m1_data_i;
    assign m_sel[0]   = wb_m0_sel_i;
    assign m_sel[1]   = wb_m1_sel_i;

    // last_grant is rewritten on every grant, so it names the owner in OWNn and TOUT
    assign owner  = last_grant_reg;
    assign owning = (state_reg == ST_OWN0) || (state_reg == ST_OWN1);

`ifdef WB_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             stall;

    assign in_tout  = (state_reg == ST_TOUT);
    assign stall    = owning && m_cyc[owner] && m_stb[owner] && !wb_s_ack_i;
    assign tout_hit = stall && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    // The counter restarts whenever the state moves (grant change, TOUT entry or exit)
    assign cnt_next = (stall && (state_next == state_reg)) ? cnt_reg + 1'b1 : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_reg <= '0;
        else          cnt_reg <= cnt_next;
    end
`else
    assign in_tout  = 1'b0;
    assign tout_hit = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (m_cyc[0] && m_cyc[1]) begin
                    last_grant_next = ~last_grant_reg;
                    state_next      = last_grant_reg ? ST_OWN0 : ST_OWN1;
                end else if (m_cyc[0]) begin
                    last_grant_next = 1'b0;
                    state_next      = ST_OWN0;
                end else if (m_cyc[1]) begin
                    last_grant_next = 1'b1;
                    state_next      = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!m_cyc[owner]) begin
                    if (m_cyc[~owner]) begin
                        last_grant_next = ~owner;
                        state_next      = owner ? ST_OWN0 : ST_OWN1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (tout_hit) begin
`ifdef WB_ARB_TIMEOUT_EN
                    state_next = ST_TOUT;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_TOUT: begin
                if (m_cyc[owner]) begin
                    state_next = owner ? ST_OWN1 : ST_OWN0;
                end else if (m_cyc[~owner]) begin
                    last_grant_next = ~owner;
                    state_next      = owner ? ST_OWN0 : ST_OWN1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Address/data/sel/we stay routed through TOUT; only stb and cyc are withdrawn
    assign wb_s_addr_o = (owning || in_tout) ? m_addr[owner]  : '0;
    assign wb_s_data_o = (owning || in_tout) ? m_wdata[owner] : '0;
    assign wb_s_sel_o  = (owning || in_tout) ? m_sel[owner]   : '0;
    assign wb_s_we_o   = (owning || in_tout) && m_we[owner];
    assign wb_s_stb_o  = owning && m_stb[owner];
    assign wb_s_cyc_o  = owning && m_cyc[owner];
    assign timeout_o   = in_tout;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign m_ack[gi]   = owning && (owner == 1'(gi)) && wb_s_ack_i;
            assign m_err[gi]   = in_tout && (owner == 1'(gi));
            assign m_rdata[gi] = (owning && (owner == 1'(gi))) ? wb_s_data_i : '0;
        end
    endgenerate

    assign wb_m0_ack_o  = m_ack[0];
    assign wb_m1_ack_o  = m_ack[1];
    assign wb_m0_err_o  = m_err[0];
    assign wb_m1_err_o  = m_err[1];
    assign wb_m0_data_o = m_rdata[0];
    assign wb_m1_data_o = m_rdata[1];
endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed scoreboard bench for wb_arbiter2 (TIMEOUT_CYCLES = 8); expectations follow WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
    logic [SW-1:0] m0_sel, m1_sel;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [SW-1:0] s_sel;
    logic          s_we, s_stb, s_cyc, s_ack, tout;

    always #5 clk = ~clk;

    wb_arbiter2 #(
        .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wb_m0_addr_i(m0_addr), .wb_m0_data_i(m0_wdata), .wb_m0_we_i(m0_we),
        .wb_m0_sel_i(m0_sel), .wb_m0_stb_i(m0_stb), .wb_m0_cyc_i(m0_cyc),
        .wb_m0_ack_o(m0_ack), .wb_m0_err_o(m0_err), .wb_m0_data_o(m0_rdata),
        .wb_m1_addr_i(m1_addr), .wb_m1_data_i(m1_wdata), .wb_m1_we_i(m1_we),
        .wb_m1_sel_i(m1_sel), .wb_m1_stb_i(m1_stb), .wb_m1_cyc_i(m1_cyc),
        .wb_m1_ack_o(m1_ack), .wb_m1_err_o(m1_err), .wb_m1_data_o(m1_rdata),
        .wb_s_addr_o(s_addr), .wb_s_data_o(s_wdata), .wb_s_sel_o(s_sel),
        .wb_s_we_o(s_we), .wb_s_stb_o(s_stb), .wb_s_cyc_o(s_cyc),
        .wb_s_ack_i(s_ack), .wb_s_data_i(s_rdata), .timeout_o(tout)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic want(input string tag, input logic [63:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic got(input string tag, input logic [63:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            e.tag = "<empty>";
            e.val = 'x;
        end else begin
            e = sb.pop_front();
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, e.val);
        assert (obs === e.val && tag == e.tag)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h (queued as %s)", tag, obs, e.val, e.tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m0_addr = '0; m1_addr = '0; m0_wdata = 32'h0A0A_0A0A; m1_wdata = 32'h0B0B_0B0B;
        m0_we = 1'b0; m1_we = 1'b1; m0_sel = 4'hF; m1_sel = 4'h3;
        m0_stb = 1'b0; m1_stb = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0;
        s_ack = 1'b0; s_rdata = '0;

        // Reset state
        repeat (2) step();
        want("rst_s_cyc", 0); want("rst_s_addr", 0); want("rst_m0_ack", 0); want("rst_tout", 0);
        @(negedge clk);
        got("rst_s_cyc", s_cyc); got("rst_s_addr", s_addr); got("rst_m0_ack", m0_ack); got("rst_tout", tout);

        // Single m0 transfer: one cycle of arbitration latency then combinational routing
        step(); rst_n = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h100;
        want("t1_latency_cyc", 0);
        @(negedge clk); got("t1_latency_cyc", s_cyc);
        step();
        want("t1_s_cyc", 1); want("t1_s_addr", 32'h100); want("t1_s_wdata", 32'h0A0A_0A0A); want("t1_s_sel", 4'hF);
        @(negedge clk);
        got("t1_s_cyc", s_cyc); got("t1_s_addr", s_addr); got("t1_s_wdata", s_wdata); got("t1_s_sel", s_sel);
        step(); s_ack = 1'b1; s_rdata = 32'h1234_5678;
        want("t1_m0_ack", 1); want("t1_m0_data", 32'h1234_5678); want("t1_m1_ack", 0); want("t1_m1_data", 0);
        @(negedge clk);
        got("t1_m0_ack", m0_ack); got("t1_m0_data", m0_rdata); got("t1_m1_ack", m1_ack); got("t1_m1_data", m1_rdata);
        step(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        want("idle_s_addr", 0); want("idle_s_cyc", 0);
        @(negedge clk); got("idle_s_addr", s_addr); got("idle_s_cyc", s_cyc);

        // Tie after reset goes to m0, then alternation
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        m0_addr = 32'hA0; m1_addr = 32'hB0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        want("tie1_addr", 32'hA0);
        @(negedge clk); got("tie1_addr", s_addr);
        step(); m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        want("handover_addr", 32'hB0); want("handover_cyc", 1);
        @(negedge clk); got("handover_addr", s_addr); got("handover_cyc", s_cyc);
        step(); m1_cyc = 1'b0; m1_stb = 1'b0;
        step(); m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        want("tie2_addr", 32'hA0);
        @(negedge clk); got("tie2_addr", s_addr);

        // m1 holds the bus over three acked transfers while m0 waits
        step(); m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step(); m1_cyc = 1'b1; m1_stb = 1'b1;
        step(); m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_rdata = 32'h1000 + 32'(i);
            want("hold_m1_ack", 1); want("hold_m1_data", 32'h1000 + 32'(i)); want("hold_m0_ack", 0);
            @(negedge clk);
            got("hold_m1_ack", m1_ack); got("hold_m1_data", m1_rdata); got("hold_m0_ack", m0_ack);
            step();
        end
        m1_cyc = 1'b0; m1_stb = 1'b0; s_rdata = 32'h2000;
        want("drop_ack_m1", 1); want("drop_ack_m0", 0);
        @(negedge clk); got("drop_ack_m1", m1_ack); got("drop_ack_m0", m0_ack);
        step(); s_rdata = 32'h3000;
        want("after_hold_m0_ack", 1); want("after_hold_m0_data", 32'h3000); want("after_hold_addr", 32'hA0);
        @(negedge clk);
        got("after_hold_m0_ack", m0_ack); got("after_hold_m0_data", m0_rdata); got("after_hold_addr", s_addr);
        step(); s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();

        // Stalled slave: timeout after eight stalled cycles when built in
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        for (int i = 0; i < TO; i++) begin
            want("stall_err", 0); want("stall_stb", 1);
            @(negedge clk); got("stall_err", m0_err); got("stall_stb", s_stb);
            step();
        end
`ifdef WB_ARB_TIMEOUT_EN
        want("tout_err", 1); want("tout_pulse", 1); want("tout_stb", 0); want("tout_cyc", 0); want("tout_m1_err", 0);
`else
        want("tout_err", 0); want("tout_pulse", 0); want("tout_stb", 1); want("tout_cyc", 1); want("tout_m1_err", 0);
`endif
        @(negedge clk);
        got("tout_err", m0_err); got("tout_pulse", tout); got("tout_stb", s_stb); got("tout_cyc", s_cyc);
        got("tout_m1_err", m1_err);
        step();
        want("post_tout_err", 0); want("post_tout_pulse", 0); want("post_tout_stb", 1);
        @(negedge clk); got("post_tout_err", m0_err); got("post_tout_pulse", tout); got("post_tout_stb", s_stb);
        step(); m0_cyc = 1'b0; m0_stb = 1'b0;
        step();

        // Ack on the eighth stalled cycle beats the timeout
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        repeat (TO - 1) step();
        s_ack = 1'b1; s_rdata = 32'h4545;
        want("race_ack", 1); want("race_err", 0); want("race_tout", 0);
        @(negedge clk); got("race_ack", m0_ack); got("race_err", m0_err); got("race_tout", tout);
        step(); s_ack = 1'b0;
        want("race_next_err", 0); want("race_next_tout", 0);
        @(negedge clk); got("race_next_err", m0_err); got("race_next_tout", tout);
        step(); m0_cyc = 1'b0; m0_stb = 1'b0;
        step();

        // Asynchronous reset during a stalled m1 transfer
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        repeat (3) step();
        s_rdata = 32'h5A5A;
        want("pre_rst_m1_data", 32'h5A5A); want("pre_rst_cyc", 1);
        @(negedge clk); got("pre_rst_m1_data", m1_rdata); got("pre_rst_cyc", s_cyc);
        #1 rst_n = 1'b0;
        #1;
        want("arst_cyc", 0); want("arst_stb", 0); want("arst_addr", 0); want("arst_m1_data", 0); want("arst_m1_err", 0);
        got("arst_cyc", s_cyc); got("arst_stb", s_stb); got("arst_addr", s_addr); got("arst_m1_data", m1_rdata);
        got("arst_m1_err", m1_err);
        step(); rst_n = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        want("post_rst_tie_addr", 32'hA0); want("post_rst_m1_data", 0);
        @(negedge clk); got("post_rst_tie_addr", s_addr); got("post_rst_m1_data", m1_rdata);

        n_cmp++;
        assert (sb.size() == 0)
        else begin
            n_bad++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 The block SHALL have parameter WB_DATA_WIDTH, default 32, giving the data bus width.
REQ-002 The block SHALL have parameter WB_ADDR_WIDTH, default 32, giving the address bus width.
REQ-003 The block SHALL have parameter WB_SEL_WIDTH, default 4, giving the byte-select width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, legal range 1..65535, giving the stalled-strobe cycles before a bus error.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port wb_m<n>_addr_i, input, WB_ADDR_WIDTH bits: master n address, for n = 0, 1.
REQ-008 The block SHALL have port wb_m<n>_data_i, input, WB_DATA_WIDTH bits: master n write data.
REQ-009 The block SHALL have port wb_m<n>_we_i, input, 1 bit: master n write enable.
REQ-010 The block SHALL have port wb_m<n>_sel_i, input, WB_SEL_WIDTH bits: master n byte selects.
REQ-011 The block SHALL have port wb_m<n>_stb_i, input, 1 bit: master n strobe.
REQ-012 The block SHALL have port wb_m<n>_cyc_i, input, 1 bit: master n cycle, which is also its bus request.
REQ-013 The block SHALL have port wb_m<n>_ack_o, output, 1 bit: master n acknowledge.
REQ-014 The block SHALL have port wb_m<n>_err_o, output, 1 bit: master n bus-timeout error.
REQ-015 The block SHALL have port wb_m<n>_data_o, output, WB_DATA_WIDTH bits: master n read data.
REQ-016 The block SHALL have port wb_s_addr_o, output, WB_ADDR_WIDTH bits: address to the downstream interconnect (wb_mux).
REQ-017 The block SHALL have ports wb_s_data_o, wb_s_sel_o, wb_s_we_o, wb_s_stb_o and wb_s_cyc_o, outputs, each at its bus width: the downstream write data, selects, write enable, strobe and cycle.
REQ-018 The block SHALL have port wb_s_ack_i, input, 1 bit: the downstream acknowledge.
REQ-019 The block SHALL have port wb_s_data_i, input, WB_DATA_WIDTH bits: the downstream read data.
REQ-020 The block SHALL have port timeout_o, output, 1 bit: a one-cycle pulse on a bus timeout, intended as an interrupt source.

Function
REQ-021 The arbiter SHALL be a registered FSM with states IDLE, OWN0, OWN1 and TOUT.
REQ-022 In IDLE with any cyc_i high, the arbiter SHALL enter OWNn on the next edge, giving one cycle of arbitration latency.
REQ-023 On simultaneous requests, the arbiter SHALL grant the master not most recently granted; the last_grant register resets to 1, so m0 wins the first tie.
REQ-024 The owner SHALL hold the grant while its cyc_i is high, regardless of the other master's requests.
REQ-025 When the owner drops cyc_i, the arbiter SHALL grant the other master on the next edge if that master's cyc_i is high, and SHALL otherwise go to IDLE.
REQ-026 In OWNn, the wb_s_* outputs SHALL equal master n's inputs combinationally.
REQ-027 In OWNn, wb_s_ack_i and wb_s_data_i SHALL route combinationally to master n, with zero added latency on the data path.
REQ-028 The non-owner's ack_o and err_o SHALL be 0 and its data_o SHALL be 0 at all times.
REQ-029 In IDLE, all wb_s_* outputs SHALL be 0.
REQ-030 If the owner drops cyc_i in the same cycle that wb_s_ack_i is high, the ack SHALL still be forwarded that cycle before the grant is released.
REQ-031 The timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide and SHALL increment each cycle the owner has stb_i and cyc_i high with wb_s_ack_i low.
REQ-032 The timeout counter SHALL clear on wb_s_ack_i, on stb_i low, and on any grant change.
REQ-033 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL enter TOUT for exactly one cycle.
REQ-034 In TOUT, the owner's err_o SHALL be 1, timeout_o SHALL be 1, wb_s_stb_o and wb_s_cyc_o SHALL be 0, and the counter SHALL clear.
REQ-035 After TOUT, the FSM SHALL return to OWNn if the owner's cyc_i is still high, and SHALL otherwise apply REQ-025.
REQ-036 If wb_s_ack_i is high in the cycle the counter would reach TIMEOUT_CYCLES, the ack SHALL win and no error SHALL be raised.

Reset
REQ-037 While rst_n_i is low, all outputs SHALL be 0 immediately (asynchronously), the state SHALL be IDLE, the counter SHALL be 0 and last_grant SHALL be 1.
REQ-038 A reset in the middle of a transfer SHALL abandon it with no ack or err issued; arbitration after reset release SHALL behave as after power-up.

Configuration
REQ-039 With macro WB_ARB_TIMEOUT_EN defined, the counter, the TOUT state, err_o and timeout_o SHALL behave as in REQ-031 to REQ-036.
REQ-040 Without WB_ARB_TIMEOUT_EN, the counter and TOUT SHALL not be built, err_o and timeout_o SHALL be tied to 0, and a stalled slave SHALL hold the bus indefinitely.

Verification
REQ-041 The bench SHALL cover: m0 cyc/stb high at cycle 1 with addr 0x100 -> wb_s_cyc_o=1, wb_s_addr_o=0x100 at cycle 2; slave ack -> m0 ack same cycle; m1 ack stays 0.
REQ-042 The bench SHALL cover: both cyc high in the first cycle after reset -> m0 granted; m0 drops cyc -> m1 granted next edge; m1 drops cyc and both request again -> m0 granted.
REQ-043 The bench SHALL cover: m1 holds cyc over 3 acked transfers while m0 requests -> m0 ack stays 0 until m1 drops cyc, and m0 is granted on the following edge.
REQ-044 The bench SHALL cover: TIMEOUT_CYCLES=8 with the slave never acking -> after 8 stalled cycles, owner err_o=1 and timeout_o=1 for 1 cycle with wb_s_stb_o=0 in that cycle; with the macro undefined -> no err ever.
REQ-045 The bench SHALL cover: TIMEOUT_CYCLES=8 with ack on the 8th stalled cycle -> ack delivered, err_o=0, timeout_o=0.
REQ-046 The bench SHALL cover: rst_n_i low during a stalled OWN1 transfer -> all outputs 0 in the same cycle; after release, a simultaneous request grants m0.
